// File: rtl/vdc_mem_sched.sv
// Slot scheduler for VDC video RAM: refresh > display fetch > CPU block engine (read/write/fill/copy).
// Latency: RAM strobes/gnt appear the cycle after slot; rd_valid/CPU results the cycle after slot_end.
// Backpressure: CPU commands use a one-deep queue; a command arriving when it is full is dropped, overrun sets.
module vdc_mem_sched #(
  parameter int ADDR_BITS = 16,
  parameter int NCH       = 4,
  parameter int WC_BITS   = 8,
  parameter int RFSH_BITS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     slot,
  input  logic                     slot_end,
  input  logic                     rfsh_start,
  input  logic [3:0]               rfsh_n,
  input  logic [NCH-1:0]           req,
  input  logic [NCH*ADDR_BITS-1:0] req_addr,
  output logic [NCH-1:0]           gnt,
  output logic [NCH-1:0]           rd_valid,
  output logic [7:0]               rd_data,
  input  logic                     cpu_start,
  input  logic [2:0]               cpu_op,
  input  logic                     cpu_dec,
  input  logic [ADDR_BITS-1:0]     ua_in,
  input  logic [ADDR_BITS-1:0]     ba_in,
  input  logic [WC_BITS-1:0]       wc_in,
  input  logic [7:0]               wd_in,
  output logic [ADDR_BITS-1:0]     ua,
  output logic [ADDR_BITS-1:0]     ba,
  output logic [7:0]               da,
  output logic                     busy,
  output logic                     overrun,
  output logic                     ram_rd,
  output logic                     ram_we,
  output logic [ADDR_BITS-1:0]     ram_addr,
  output logic [7:0]               ram_di,
  input  logic [7:0]               ram_do
);

  localparam int CH_BITS = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WR, S_FILL, S_CP_RD, S_CP_WR
  } state_t;

  // What the current slot issued, so slot_end knows whom to complete.
  typedef enum logic [1:0] {
    R_NONE, R_FETCH, R_CPU
  } rec_t;

  // CPU engine
  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   ua_q, ua_d;
  logic [ADDR_BITS-1:0]   ba_q, ba_d;
  logic [WC_BITS-1:0]     cnt_q, cnt_d;
  logic [7:0]             wd_q, wd_d;
  logic                   dec_q, dec_d;
  logic [7:0]             hold_q, hold_d;
  logic [7:0]             da_q, da_d;
  logic                   overrun_q, overrun_d;

  // One-deep command queue
  logic                   qv_q, qv_d;
  logic [2:0]             q_op_q, q_op_d;
  logic                   q_dec_q, q_dec_d;
  logic [ADDR_BITS-1:0]   q_ua_q, q_ua_d;
  logic [ADDR_BITS-1:0]   q_ba_q, q_ba_d;
  logic [WC_BITS-1:0]     q_wc_q, q_wc_d;
  logic [7:0]             q_wd_q, q_wd_d;

  // Refresh
  logic [3:0]             rfsh_bud_q, rfsh_bud_d;
  logic [RFSH_BITS-1:0]   rfsh_addr_q, rfsh_addr_d;

  // Slot bookkeeping
  rec_t                   rec_q, rec_d;
  logic [CH_BITS-1:0]     rec_ch_q, rec_ch_d;

  // Registered outputs
  logic [NCH-1:0]         gnt_q, gnt_d;
  logic [NCH-1:0]         rd_valid_q, rd_valid_d;
  logic [7:0]             rd_data_q, rd_data_d;
  logic                   ram_rd_q, ram_rd_d;
  logic                   ram_we_q, ram_we_d;
  logic [ADDR_BITS-1:0]   ram_addr_q, ram_addr_d;
  logic [7:0]             ram_di_q, ram_di_d;

  logic                   fetch_any;
  logic [CH_BITS-1:0]     fetch_ch;
  logic [ADDR_BITS-1:0]   step;

  // Address step; all-ones is -1 modulo 2^ADDR_BITS.
  assign step = dec_q ? {ADDR_BITS{1'b1}} : {{(ADDR_BITS-1){1'b0}}, 1'b1};

  function automatic state_t op_state(input logic [2:0] op);
    case (op)
      3'd0:    op_state = S_RD;
      3'd1:    op_state = S_WR;
      3'd2:    op_state = S_FILL;
      3'd3:    op_state = S_CP_RD;
      default: op_state = S_IDLE;  // unknown opcodes are no-ops
    endcase
  endfunction

  // Lowest-index asserted fetch request wins.
  always_comb begin
    fetch_any = 1'b0;
    fetch_ch  = '0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (req[c]) begin
        fetch_any = 1'b1;
        fetch_ch  = c[CH_BITS-1:0];
      end
    end
  end

  // Next state: slot_end completion first, then slot issue, then command start/queue, then refresh load.
  always_comb begin
    state_d     = state_q;
    ua_d        = ua_q;
    ba_d        = ba_q;
    cnt_d       = cnt_q;
    wd_d        = wd_q;
    dec_d       = dec_q;
    hold_d      = hold_q;
    da_d        = da_q;
    overrun_d   = overrun_q;
    qv_d        = qv_q;
    q_op_d      = q_op_q;
    q_dec_d     = q_dec_q;
    q_ua_d      = q_ua_q;
    q_ba_d      = q_ba_q;
    q_wc_d      = q_wc_q;
    q_wd_d      = q_wd_q;
    rfsh_bud_d  = rfsh_bud_q;
    rfsh_addr_d = rfsh_addr_q;
    rec_d       = rec_q;
    rec_ch_d    = rec_ch_q;
    gnt_d       = '0;
    rd_valid_d  = '0;
    rd_data_d   = rd_data_q;
    ram_rd_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_di_d    = ram_di_q;

    if (slot_end) begin
      rec_d = R_NONE;
      if (rec_q == R_FETCH) begin
        rd_valid_d[rec_ch_q] = 1'b1;
        rd_data_d            = ram_do;
      end else if (rec_q == R_CPU) begin
        case (state_q)
          S_RD: begin
            da_d    = ram_do;
            state_d = S_IDLE;
          end
          S_WR: begin
            ua_d    = ua_q + step;
            state_d = S_RD;
          end
          S_FILL: begin
            ua_d  = ua_q + step;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == {{(WC_BITS-1){1'b0}}, 1'b1}) state_d = S_IDLE;
          end
          S_CP_RD: begin
            hold_d  = ram_do;
            ba_d    = ba_q + step;
            state_d = S_CP_WR;
          end
          S_CP_WR: begin
            ua_d    = ua_q + step;
            cnt_d   = cnt_q - 1'b1;
            state_d = (cnt_q == {{(WC_BITS-1){1'b0}}, 1'b1}) ? S_IDLE : S_CP_RD;
          end
          default: ;
        endcase
      end
    end

    // Slot issue sees the engine state as already updated by a coincident slot_end.
    if (slot) begin
      rec_d      = R_NONE;
      ram_addr_d = '1;
      if (rfsh_bud_q != 4'd0) begin
        ram_rd_d                   = 1'b1;
        ram_addr_d                 = '0;
        ram_addr_d[RFSH_BITS-1:0]  = rfsh_addr_q;
        rfsh_addr_d                = rfsh_addr_q + 1'b1;
        rfsh_bud_d                 = rfsh_bud_q - 4'd1;
      end else if (fetch_any) begin
        ram_rd_d          = 1'b1;
        ram_addr_d        = req_addr[fetch_ch*ADDR_BITS +: ADDR_BITS];
        gnt_d[fetch_ch]   = 1'b1;
        rec_d             = R_FETCH;
        rec_ch_d          = fetch_ch;
      end else if (state_d != S_IDLE) begin
        rec_d = R_CPU;
        case (state_d)
          S_RD: begin
            ram_rd_d   = 1'b1;
            ram_addr_d = ua_d;
          end
          S_WR, S_FILL: begin
            ram_we_d   = 1'b1;
            ram_addr_d = ua_d;
            ram_di_d   = wd_q;
          end
          S_CP_RD: begin
            ram_rd_d   = 1'b1;
            ram_addr_d = ba_d;
          end
          S_CP_WR: begin
            ram_we_d   = 1'b1;
            ram_addr_d = ua_d;
            ram_di_d   = hold_d;
          end
          default: ;
        endcase
      end
    end

    // A command starts only from a registered IDLE, so a queued one starts the cycle after the engine returns.
    if (state_q == S_IDLE) begin
      if (qv_q) begin
        state_d = op_state(q_op_q);
        ua_d    = q_ua_q;
        ba_d    = q_ba_q;
        cnt_d   = q_wc_q;
        wd_d    = q_wd_q;
        dec_d   = q_dec_q;
        qv_d    = cpu_start;
        if (cpu_start) begin
          q_op_d  = cpu_op;
          q_dec_d = cpu_dec;
          q_ua_d  = ua_in;
          q_ba_d  = ba_in;
          q_wc_d  = wc_in;
          q_wd_d  = wd_in;
        end
      end else if (cpu_start) begin
        state_d = op_state(cpu_op);
        ua_d    = ua_in;
        ba_d    = ba_in;
        cnt_d   = wc_in;
        wd_d    = wd_in;
        dec_d   = cpu_dec;
      end
    end else if (cpu_start) begin
      if (qv_q) begin
        overrun_d = 1'b1;
      end else begin
        qv_d    = 1'b1;
        q_op_d  = cpu_op;
        q_dec_d = cpu_dec;
        q_ua_d  = ua_in;
        q_ba_d  = ba_in;
        q_wc_d  = wc_in;
        q_wd_d  = wd_in;
      end
    end

    // A fresh budget load overrides the decrement of a coincident refresh slot.
    if (rfsh_start) rfsh_bud_d = rfsh_n;
  end

  // State register with synchronous reset; reset also drops any pending slot_end completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ua_q        <= '0;
      ba_q        <= '0;
      cnt_q       <= '0;
      wd_q        <= '0;
      dec_q       <= 1'b0;
      hold_q      <= '0;
      da_q        <= '0;
      overrun_q   <= 1'b0;
      qv_q        <= 1'b0;
      q_op_q      <= '0;
      q_dec_q     <= 1'b0;
      q_ua_q      <= '0;
      q_ba_q      <= '0;
      q_wc_q      <= '0;
      q_wd_q      <= '0;
      rfsh_bud_q  <= '0;
      rfsh_addr_q <= '0;
      rec_q       <= R_NONE;
      rec_ch_q    <= '0;
      gnt_q       <= '0;
      rd_valid_q  <= '0;
      rd_data_q   <= '0;
      ram_rd_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '1;
      ram_di_q    <= '0;
    end else begin
      state_q     <= state_d;
      ua_q        <= ua_d;
      ba_q        <= ba_d;
      cnt_q       <= cnt_d;
      wd_q        <= wd_d;
      dec_q       <= dec_d;
      hold_q      <= hold_d;
      da_q        <= da_d;
      overrun_q   <= overrun_d;
      qv_q        <= qv_d;
      q_op_q      <= q_op_d;
      q_dec_q     <= q_dec_d;
      q_ua_q      <= q_ua_d;
      q_ba_q      <= q_ba_d;
      q_wc_q      <= q_wc_d;
      q_wd_q      <= q_wd_d;
      rfsh_bud_q  <= rfsh_bud_d;
      rfsh_addr_q <= rfsh_addr_d;
      rec_q       <= rec_d;
      rec_ch_q    <= rec_ch_d;
      gnt_q       <= gnt_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      ram_rd_q    <= ram_rd_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_di_q    <= ram_di_d;
    end
  end

  assign gnt      = gnt_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign ua       = ua_q;
  assign ba       = ba_q;
  assign da       = da_q;
  assign overrun  = overrun_q;
  assign ram_rd   = ram_rd_q;
  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_di   = ram_di_q;
  assign busy     = (state_q != S_IDLE) | qv_q | cpu_start;

endmodule
